// File: rtl/fnd_scan_controller_if.sv
// Handshake and display bus between a load source, the scan controller and the FND decoder.
interface fnd_scan_controller_if;
  logic        i_load;
  logic [13:0] i_bin;
  logic        o_busy;
  logic        o_done;
  logic        o_ovf;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_value;
  logic        o_en;

  modport master (
    output i_load, i_bin,
    input  o_busy, o_done, o_ovf, o_digitSelect, o_value, o_en
  );

  modport slave (
    input  i_load, i_bin,
    output o_busy, o_done, o_ovf, o_digitSelect, o_value, o_en
  );
endinterface

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD converter (sequential double dabble) feeding a free-running 4-digit FND scan.
module fnd_scan_controller #(
  parameter int unsigned PRESCALE = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  fnd_scan_controller_if.slave   fnd_io
);

  localparam int unsigned    CntW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);
  localparam logic [13:0]    BinMax = 14'd9999;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [13:0]     bin_q, bin_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [3:0]      iter_q, iter_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [15:0]     disp_q, disp_d;
  logic [15:0]     adj;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0]      val_q, val_d;
  logic            en_q, en_d;
  logic            upper_zero;

  // Conversion FSM: latch clamped input, 14 add-3/shift steps, then publish to display reg.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    disp_d  = disp_q;
    adj     = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      StIdle: begin
        if (fnd_io.i_load) begin
          bin_d   = (fnd_io.i_bin > BinMax) ? BinMax : fnd_io.i_bin;
          ovf_d   = (fnd_io.i_bin > BinMax);
          bcd_d   = '0;
          iter_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Top bit of the adjusted accumulator is always 0 for inputs <= 9999.
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd13) state_d = StDone;
      end
      StDone: begin
        disp_d  = bcd_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan: prescaler advances the digit index; outputs are registered from index and display.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
    upper_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    sel_d = idx_q;
    val_d = disp_q[4*idx_q +: 4];
    en_d  = !(BLANK_LZ && (idx_q != 2'd0) && upper_zero);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      val_q   <= '0;
      en_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      en_q    <= en_d;
    end
  end

  assign fnd_io.o_busy        = (state_q != StIdle);
  assign fnd_io.o_done        = done_q;
  assign fnd_io.o_ovf         = ovf_q;
  assign fnd_io.o_digitSelect = sel_q;
  assign fnd_io.o_value       = val_q;
  assign fnd_io.o_en          = en_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench: three controller instances (P=4/blank, P=4/no-blank, P=1/blank) share one stimulus;
// a monitor compares every cycle against a decimal-arithmetic reference model.
module tb_fnd_scan_controller;

  typedef struct {
    int cyc;
    int bin;
  } load_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] bin = '0;

  logic        busy_w [3];
  logic        done_w [3];
  logic        ovf_w  [3];
  logic        en_w   [3];
  logic [1:0]  sel_w  [3];
  logic [3:0]  val_w  [3];

  load_t log_q[$];
  int    cyc = 0;
  int    free_at = 0;
  bit    end_req = 1'b0;

  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ps_of(input int g);
    return (g == 2) ? 1 : 4;
  endfunction

  function automatic bit blz_of(input int g);
    return (g == 1) ? 1'b0 : 1'b1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fnd_scan_controller_if bus ();
    assign bus.i_load = load;
    assign bus.i_bin  = bin;
    assign busy_w[g]  = bus.o_busy;
    assign done_w[g]  = bus.o_done;
    assign ovf_w[g]   = bus.o_ovf;
    assign sel_w[g]   = bus.o_digitSelect;
    assign val_w[g]   = bus.o_value;
    assign en_w[g]    = bus.o_en;

    fnd_scan_controller #(
      .PRESCALE ((g == 2) ? 1 : 4),
      .BLANK_LZ ((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .fnd_io    (bus.slave)
    );
  end

  task automatic check(input string name, input int g, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, g, cyc, act, exp);
    end
  endtask

  // Monitor / reference model state
  int rd = 0;
  int disp_m = 0;
  int disp_nx = 0;
  bit disp_upd = 1'b0;
  bit ovf_m = 1'b0;
  int scan_k = 0;
  bit seen_rst = 1'b0;
  bit end_done = 1'b0;
  bit busy_e, done_e, en_e;
  int sel_e, val_e, pw;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      seen_rst = 1'b1;
      scan_k   = 0;
      rd       = log_q.size();
      disp_m   = 0;
      disp_upd = 1'b0;
      ovf_m    = 1'b0;
    end else begin
      scan_k++;
    end
    if (seen_rst) begin
      if (disp_upd) begin
        disp_m   = disp_nx;
        disp_upd = 1'b0;
      end
      busy_e = 1'b0;
      done_e = 1'b0;
      if (rst_n && rd < log_q.size() && log_q[rd].cyc <= cyc) begin
        if (log_q[rd].cyc == cyc) ovf_m = (log_q[rd].bin > 9999);
        busy_e = (cyc < log_q[rd].cyc + 15);
        done_e = (cyc == log_q[rd].cyc + 15);
      end
      for (int g = 0; g < 3; g++) begin
        sel_e = (scan_k == 0) ? 0 : ((scan_k - 1) / ps_of(g)) % 4;
        pw = 1;
        for (int j = 0; j < sel_e; j++) pw = pw * 10;
        val_e = (disp_m / pw) % 10;
        en_e  = (sel_e == 0) || !blz_of(g) || (disp_m >= pw);
        check("busy", g, int'(busy_w[g]), int'(busy_e));
        check("done", g, int'(done_w[g]), int'(done_e));
        check("ovf",  g, int'(ovf_w[g]),  int'(ovf_m));
        check("sel",  g, int'(sel_w[g]),  sel_e);
        check("value", g, int'(val_w[g]), val_e);
        check("en",   g, int'(en_w[g]),   int'(en_e));
      end
      if (done_e) begin
        disp_nx  = (log_q[rd].bin > 9999) ? 9999 : log_q[rd].bin;
        disp_upd = 1'b1;
        rd++;
      end
      if (end_req && !end_done) begin
        check("drained", 0, rd, log_q.size());
        end_done = 1'b1;
      end
    end
  end

  // A load is expected to be accepted only when no conversion is in flight.
  task automatic do_load(input int b);
    int n;
    @(negedge clk);
    n = cyc + 1;
    load = 1'b1;
    bin  = 14'(b);
    if (n >= free_at) begin
      log_q.push_back('{n, b});
      free_at = n + 16;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    free_at = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b;
    do_reset(3);
    idle(24);
    do_load(1234);
    idle(40);
    do_load(7);
    idle(30);
    do_load(1005);
    idle(30);
    do_load(12000);
    idle(30);
    do_load(0);
    idle(30);
    do_load(4321);
    idle(3);
    do_load(99);
    idle(40);
    do_load(55);
    idle(6);
    do_reset(2);
    idle(24);
    do_load(9876);
    idle(30);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       b = int'($urandom_range(0, 9));
        1:       b = int'($urandom_range(9990, 10010));
        default: b = int'($urandom_range(0, 16383));
      endcase
      do_load(b);
      idle(int'($urandom_range(0, 22)));
    end
    idle(40);
    end_req = 1'b1;
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
